// File: rtl/result_capture_fifo.sv
// Generic single-clock FIFO: registered pointers and occupancy, unregistered head-of-queue read data.
// Latency: a push at edge N is visible at the head from edge N+1; no fall-through.
// Backpressure: none internally; the caller must not push when full unless it pops in the same cycle.
module fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     push_vld,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop_rdy,
    output logic [WIDTH-1:0]         pop_dat,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_vld) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_vld) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_rdy) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push_vld && !pop_rdy) begin
                count <= count + CW'(1);
            end else if (!push_vld && pop_rdy) begin
                count <= count - CW'(1);
            end
        end
    end
endmodule

// Captures the core result bus into a FIFO (optionally skipping repeats) and serves one pop per rd_req.
// Latency: a sample is counted at its capture edge; rd_data/rd_valid are registered, one edge after rd_req.
// Backpressure: none toward the core; samples arriving while full (without a same-cycle pop) are dropped and flag overflow.
module result_capture_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int DEDUP = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ena,
    input  logic [WIDTH-1:0]         res_in,
    input  logic                     res_valid,
    input  logic                     clr,
    input  logic                     rd_req,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     rd_valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full,
    output logic                     overflow
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] last;
    logic             have_last;
    logic [WIDTH-1:0] head_dat;
    logic             clr_en;
    logic             cand;
    logic             push;
    logic             pop;
    logic             drop;

    assign empty  = (count == '0);
    assign full   = (count == CW'(DEPTH));
    assign clr_en = ena & clr;
    assign pop    = ena & rd_req & ~clr & ~empty;
    assign cand   = ena & res_valid & ~clr & ((DEDUP == 0) | ~have_last | (res_in != last));
    // A full FIFO still takes the sample when the head leaves in the same cycle.
    assign push   = cand & (~full | pop);
    assign drop   = cand & ~push;

    fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr_en),
        .push_vld (push),
        .push_dat (res_in),
        .pop_rdy  (pop),
        .pop_dat  (head_dat),
        .count    (count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            overflow  <= 1'b0;
            last      <= '0;
            have_last <= 1'b0;
        end else if (clr_en) begin
            rd_valid  <= 1'b0;
            overflow  <= 1'b0;
            have_last <= 1'b0;
        end else begin
            rd_valid <= pop;
            if (pop) begin
                rd_data <= head_dat;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
            if (push) begin
                last      <= res_in;
                have_last <= 1'b1;
            end
        end
    end
endmodule

// File: doc/result_capture_fifo.md
# result_capture_fifo

Captures the 8-bit result bus of the TinyTapeout processor core (`uo_out`) on the same clock and buffers each new value in a small FIFO. A host or bench then drains the captured values through a one-request, one-response read port. It is the receive end of the operand stream driven into `ui_in`/`uio_in`: stimulus goes in on one side, and this block collects the responses. It sits beside the core inside the `tt_um_*` top level.

## Interface
- `WIDTH`, 8: result and read-data width in bits.
- `DEPTH`, 8: number of FIFO entries; must be a power of two, ≥ 2.
- `DEDUP`, 1: when 1, a sample equal to the last accepted value is not pushed; when 0, every valid sample is pushed.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `ena`  in  1: block enable; when low, no push, no pop, all state held.
- `res_in`  in  WIDTH: result bus sampled from the core.
- `res_valid`  in  1: `res_in` is meaningful this cycle.
- `clr`  in  1: synchronous clear.
- `rd_req`  in  1: read request; one pop per high cycle.
- `rd_data`  out  WIDTH: last popped value; registered.
- `rd_valid`  out  1: one-cycle pulse marking a new `rd_data`.
- `count`  out  $clog2(DEPTH)+1: current occupancy, 0..DEPTH.
- `empty`  out  1: `count == 0`.
- `full`  out  1: `count == DEPTH`.
- `overflow`  out  1: sticky flag, set when a push is dropped because the FIFO is full.

## Operation
- **Reset (async, `rst_n` low):**
  - `rd_data`=0, `rd_valid`=0, `count`=0, `empty`=1, `full`=0, `overflow`=0.
  - Read/write pointers cleared; last-value register cleared; `have_last`=0.
- **Push candidate:** `ena & res_valid & ~clr & (DEDUP==0 | ~have_last | res_in != last)`.
- **Accept / drop:**
  - A candidate is accepted if not full, or if full and a pop occurs in the same cycle.
  - Otherwise it is dropped and `overflow` is set.
- **On accept:** write `res_in` at the write pointer, advance the pointer (wraps modulo DEPTH), set `last`=`res_in`, set `have_last`=1.
  - A dropped sample does not update `last`.
- **Pop:** `ena & rd_req & ~clr & ~empty`.
  - The entry at the read pointer is loaded into `rd_data`, `rd_valid` pulses for one cycle, and the read pointer advances (wraps).
  - `rd_req` while empty is ignored: no pulse, `rd_data` unchanged.
  - There is no fall-through: a value pushed in cycle N is poppable from cycle N+1 onward.
- **Occupancy update:** simultaneous push and pop leaves `count` unchanged; otherwise `count` moves by ±1.
- **`clr` (takes priority over everything):**
  - Pointers reset, `count`=0, `overflow`=0, `have_last`=0, `rd_valid`=0.
  - `rd_data` is held.
- **`ena` low:** everything above is suppressed. `rd_valid` is forced to 0 on the next edge, and all other state holds.

## Timing
- Capture latency: `res_in` at edge N is counted at edge N; `count`/`empty` reflect it after edge N.
- Read latency: `rd_req` high at edge N gives `rd_data`/`rd_valid` valid after edge N, for exactly one cycle.
- Back-to-back `rd_req` yields one pop per cycle until empty.
- Flags (`full`, `empty`, `overflow`) are registered or derived from registered `count`; no combinational path from inputs to outputs.
- `overflow` sets on the edge of the dropped push and holds until `clr` or reset.
- Reset asserted mid-operation clears all state immediately, without waiting for a clock edge. The first accepted sample after release is always pushed, even if it equals the pre-reset value.

## Test plan
- **Reset values:** `rst_n` low 50 ns, release → all outputs at reset values; `rd_req` on empty → `rd_valid` stays 0.
- **Ordered capture with DEDUP=1:** push 0x00, 0x01, 0x01, 0x02 with `res_valid`=1 → `count`=3; three `rd_req` → `rd_data` 0x00, 0x01, 0x02, each with a single `rd_valid` pulse; `empty`=1.
- **Full and overflow:** push 0x10..0x18 (9 distinct values) with no reads → `full`=1, `count`=8, `overflow`=1. Drain → 0x10..0x17; 0x18 is lost.
- **Simultaneous push/pop when full:** with the FIFO full, push 0x55 and assert `rd_req` in the same cycle → `count` stays 8, `overflow` stays 0. After draining, 0x55 is the last value out.
- **Pointer wrap-around:** interleave 20 pushes (0x20..0x33) with 20 pops at a one-cycle lag → output sequence matches the input sequence exactly; `count` never exceeds 2.
- **`clr` and `ena`:**
  - `clr` with `count`=5 and `overflow`=1 → `count`=0, `overflow`=0, `rd_data` held; a re-push of the last value is accepted.
  - With `ena`=0, `res_valid` and `rd_req` toggling → no state change.
